// File: rtl/serial_tx_moore_if.sv
// Parallel-in / serial-out link bundle between a word producer and the frame transmitter.
// The transmitter sits on the slave side.
interface serial_tx_moore_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (output start, output data_in, input tx, input busy, input done);
  modport slave  (input start, input data_in, output tx, output busy, output done);
endinterface

// File: rtl/serial_tx_moore.sv
// Moore serial frame transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// with each bit held for CLKS_PER_BIT clocks. Outputs depend only on registered state.
module serial_tx_moore #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  serial_tx_moore_if.slave link
);
  // Counter widths stay at least 1 bit so the degenerate parameter values still elaborate.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  baud_reg,  baud_next;
  logic [IDX_W-1:0]  idx_reg,   idx_next;

  logic             bit_end;
  logic [CNT_W-1:0] baud_step;

  // With CLKS_PER_BIT=1 CNT_LAST is 0, so every cycle ends a bit and the counter stays at 0.
  assign bit_end   = (baud_reg == CNT_LAST);
  assign baud_step = bit_end ? '0 : baud_reg + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      shift_reg <= '0;
      baud_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      baud_reg  <= baud_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    baud_next  = baud_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        baud_next = '0;
        idx_next  = '0;
        if (link.start) begin
          shift_next = link.data_in;
          state_next = S_START;
        end
      end
      S_START: begin
        baud_next = baud_step;
        if (bit_end) begin
          idx_next   = '0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        baud_next = baud_step;
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == IDX_LAST) begin
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        baud_next = baud_step;
        if (bit_end) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        baud_next  = '0;
        state_next = S_IDLE;
      end
      default: begin
        baud_next  = '0;
        idx_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Unused codes fall through to the idle line levels while they recover.
  always_comb begin
    link.tx   = 1'b1;
    link.busy = 1'b0;
    link.done = 1'b0;
    case (state_reg)
      S_START: begin
        link.tx   = 1'b0;
        link.busy = 1'b1;
      end
      S_DATA: begin
        link.tx   = shift_reg[0];
        link.busy = 1'b1;
      end
      S_STOP: begin
        link.busy = 1'b1;
      end
      S_DONE: begin
        link.busy = 1'b1;
        link.done = 1'b1;
      end
      default: begin
        link.tx   = 1'b1;
        link.busy = 1'b0;
        link.done = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_serial_tx_moore.sv
// Scoreboarded bench for serial_tx_moore: a 4-clock-per-bit and a 1-clock-per-bit instance,
// each watched by a frame monitor that compares the line against queued expected words.
module tb_serial_tx_moore;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int   tests = 0;
  int   fails = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  serial_tx_moore_if #(.DATA_W(DW)) if0 ();
  serial_tx_moore_if #(.DATA_W(DW)) if1 ();

  serial_tx_moore #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut0 (.clk(clk), .reset(rst0), .link(if0));
  serial_tx_moore #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .reset(rst1), .link(if1));

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // {reset, tx, busy, done} of one instance
  function automatic logic [3:0] sample(int k);
    if (k == 0) return {rst0, if0.tx, if0.busy, if0.done};
    return {rst1, if1.tx, if1.busy, if1.done};
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DW-1:0] qfront(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(int k, logic [DW-1:0] d);
    if (k == 0) q0.push_back(d);
    else        q1.push_back(d);
  endfunction

  task automatic drive(int k, logic s, logic [DW-1:0] d);
    if (k == 0) begin
      if0.start = s; if0.data_in = d;
    end else begin
      if1.start = s; if1.data_in = d;
    end
  endtask

  // Frame monitor: bit b of a frame is expected on cycles b*cpb .. b*cpb+cpb-1 after busy rises.
  task automatic monitor(int k, int cpb);
    int            pos = -1;
    int            b;
    logic [DW-1:0] word = '0;
    logic          bad = 1'b0;
    logic          after_done = 1'b0;
    logic          r, tx, busy, done, eb;
    forever begin
      @(negedge clk);
      {r, tx, busy, done} = sample(k);
      if (r) begin
        check($sformatf("dut%0d_reset_outputs", k), {tx, busy, done}, 3'b100);
        if (pos >= 0) begin
          $display("[TB] dut%0d frame %02h abandoned by reset", k, word);
          qpop(k);
          pos = -1;
        end
        after_done = 1'b0;
      end else begin
        if (pos < 0) begin
          if (after_done) begin
            check($sformatf("dut%0d_idle_after_done", k), busy, 1'b0);
            after_done = 1'b0;
          end
          if (busy) begin
            if (qsize(k) == 0) begin
              check($sformatf("dut%0d_unexpected_frame", k), 1, 0);
            end else begin
              word = qfront(k);
              pos  = 0;
              bad  = 1'b0;
            end
          end else begin
            check($sformatf("dut%0d_idle_line", k), {tx, done}, 2'b10);
          end
        end
        if (pos >= 0) begin
          if (pos < (DW + 2) * cpb) begin
            b  = pos / cpb;
            eb = (b == 0) ? 1'b0 : (b == DW + 1) ? 1'b1 : word[b-1];
            if (tx !== eb || busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
            if (pos % cpb == cpb - 1) begin
              tests++;
              if (bad) begin
                fails++;
                $display("FAIL dut%0d_frame_bit%0d (word %02h): got tx=%b busy=%b done=%b, required tx=%b busy=1 done=0 for %0d cycles",
                         k, b, word, tx, busy, done, eb, cpb);
              end
              bad = 1'b0;
            end
            pos++;
          end else begin
            check($sformatf("dut%0d_done_cycle", k), {tx, busy, done}, 3'b111);
            $display("[TB] dut%0d frame %02h sent", k, word);
            qpop(k);
            pos        = -1;
            after_done = 1'b1;
          end
        end
      end
    end
  endtask

  initial monitor(0, 4);
  initial monitor(1, 1);

  task automatic wait_done(int k, int limit, string tag);
    logic seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (sample(k)[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("dut%0d_%s_done_seen", k, tag), seen, 1'b1);
  endtask

  // Called at a negedge of an IDLE cycle: one-cycle start pulse, then wait for the frame's done.
  task automatic send(int k, logic [DW-1:0] d, int cpb);
    drive(k, 1'b1, d);
    qpush(k, d);
    @(negedge clk);
    drive(k, 1'b0, DW'($urandom));
    wait_done(k, (DW + 2) * cpb + 4, "frame");
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("dut0_reset_state", {if0.tx, if0.busy, if0.done}, 3'b100);
    check("dut1_reset_state", {if1.tx, if1.busy, if1.done}, 3'b100);
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (20) @(negedge clk);

    fork
      begin
        logic found;
        int   gap;
        send(0, 8'hA5, 4);
        @(negedge clk);

        // start held high through the frame, data changed mid-frame
        drive(0, 1'b1, 8'hA5);
        qpush(0, 8'hA5);
        qpush(0, 8'h3C);
        repeat (10) @(negedge clk);
        drive(0, 1'b1, 8'h3C);
        wait_done(0, 50, "held_first");
        found = 1'b0;
        gap   = 0;
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          gap++;
          if (if0.busy) begin
            found = 1'b1;
            break;
          end
        end
        check("dut0_held_restart_gap", found ? gap : -1, 2);
        drive(0, 1'b0, '0);
        wait_done(0, 50, "held_second");
        @(negedge clk);

        // reset during data bit 3 of a 0xFF frame
        drive(0, 1'b1, 8'hFF);
        qpush(0, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, '0);
        repeat (17) @(negedge clk);
        #2 rst0 = 1'b1;
        #1 check("dut0_async_reset_outputs", {if0.tx, if0.busy, if0.done}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        #2 rst0 = 1'b0;
        @(negedge clk);
        send(0, 8'h00, 4);
        @(negedge clk);

        // illegal state code recovers to IDLE after one edge
        #1 force dut0.state_reg = 3'd6;
        #1 check("dut0_illegal_line", {if0.tx, if0.done}, 2'b10);
        release dut0.state_reg;
        @(posedge clk);
        #1 check("dut0_illegal_recovers", dut0.state_reg, 3'd0);
        @(negedge clk);

        repeat (12) begin
          send(0, DW'($urandom), 4);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      begin
        send(1, 8'h01, 1);
        @(negedge clk);
        repeat (30) begin
          send(1, DW'($urandom), 1);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("dut0_queue_drained", q0.size(), 0);
    check("dut1_queue_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
